// File: rtl/npc_pkg.sv
// Shared definitions for the npc core: fetch FSM states, reset PC, NOP encoding
// and the instruction/address widths used by both ifu and cpu.
package npc_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam logic [ILEN-1:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_t;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one imem request/response per instruction, holds the
// fetched word on cmd until the core takes it, then pulses pc_wen.
module ifu
  import npc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = npc_pkg::RESET_PC,
  parameter logic [ILEN-1:0] NOP      = npc_pkg::NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            pc_wen,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            imem_err,
  output logic [ILEN-1:0] cmd,
  output logic [XLEN-1:0] cmd_pc,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic            cmd_err,
  output logic [1:0]      fsm_state
);

  // Handshakes: imem_req/imem_addr are held until imem_gnt (never withdrawn);
  // cmd/cmd_pc/cmd_err are held while cmd_valid until cmd_ready, flush wins.
  ifu_state_t      state_q;
  logic [XLEN-1:0] addr_q;
  logic [ILEN-1:0] cmd_q;
  logic [XLEN-1:0] cmd_pc_q;
  logic            cmd_err_q;
  logic            drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cmd_q     <= '0;
      cmd_pc_q  <= RESET_PC;
      cmd_err_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          addr_q <= pc;
          if (pc[1:0] != 2'b00) begin
            cmd_q     <= NOP;
            cmd_err_q <= 1'b1;
            cmd_pc_q  <= pc;
            state_q   <= HOLD;
          end else begin
            state_q <= REQ;
          end
        end
        REQ: begin
          // A flushed request still completes; its response is dropped in WAIT.
          if (flush) drop_q <= 1'b1;
          if (imem_gnt) state_q <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (drop_q || flush) begin
              drop_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              cmd_q     <= imem_err ? NOP : imem_rdata;
              cmd_err_q <= imem_err;
              cmd_pc_q  <= addr_q;
              state_q   <= HOLD;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        HOLD: begin
          if (flush || cmd_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = addr_q;
  assign cmd_valid = (state_q == HOLD);
  assign pc_wen    = (state_q == HOLD) && cmd_ready && !flush;
  assign cmd       = cmd_q;
  assign cmd_pc    = cmd_pc_q;
  assign cmd_err   = cmd_err_q;
  assign fsm_state = state_q;

endmodule
